perf_readout: RTL and testbench
===============================

# perf_readout

Consumer side of the accelerator's performance-counter path. It captures each completed measurement snapshot (six counters plus a done pulse) into a small FIFO of records. Records are exposed to software through a simple one-cycle CSR read/write port with pop-on-command semantics, and an interrupt is raised while records are pending. It sits between the performance monitor and the CSR block, so back-to-back inferences are not lost when software reads late.

## Interface
- COUNTER_WIDTH, 32: width of incoming snapshot counters; legal range 1..32; zero-extended to 32 on readout
- DEPTH, 4: snapshot FIFO depth; power of two, 2..16
- clk  in  1  the single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- snap_valid  in  1  one-cycle pulse: snapshot inputs valid this cycle
- snap_total, snap_active, snap_idle  in  COUNTER_WIDTH  cycle counters of the finished measurement
- snap_dma_bytes, snap_blocks, snap_stalls  in  32  DMA bytes, blocks processed, stall cycles
- rd_req  in  1  CSR read strobe
- rd_addr  in  8  byte address, word-aligned; bits [1:0] ignored
- rd_valid  out  1  read data valid, exactly one cycle after rd_req
- rd_data  out  32  read data
- wr_req  in  1  CSR write strobe
- wr_addr  in  8  byte address, word-aligned
- wr_data  in  32  write data
- irq  out  1  level interrupt: irq_en & FIFO non-empty

## Operation
- Register map, all 32-bit:
  - 0x00 STATUS (RO except bit2): bit0 empty, bit1 full, bit2 ovf sticky (W1C), [7:3] zero, [15:8] level, [31:16] overflow count (saturating at 0xFFFF; cleared by the same W1C)
  - 0x04 TOTAL, 0x08 ACTIVE, 0x0C IDLE, 0x10 DMA_BYTES, 0x14 BLOCKS, 0x18 STALLS: fields of the head record; read 0 when empty
  - 0x1C POP: write of any value pops the head record; reads 0
  - 0x20 CTRL: bit0 irq_en (RW); bit1 flush (write 1 empties FIFO, self-clearing, reads 0)
  - Unmapped reads return 0; unmapped writes are ignored
- Push: snap_valid stores all six fields as one record at the tail.
- Full and no pop in the same cycle: the new record is dropped, ovf is set, and the overflow count increments. The oldest data is preserved.
- Push and pop in the same cycle while full: both take effect, level stays DEPTH, no overflow.
- Pop when empty: ignored, no error.
- Flush has priority over push and pop in the same cycle: FIFO empties, the concurrent push is discarded and is not counted as overflow.
- Overflow event and a W1C clear in the same cycle: the event wins, leaving ovf=1 and count=1.
- Read and write in the same cycle: both accepted; the read returns the pre-write value.
- Reset: FIFO empty, level 0, ovf 0, overflow count 0, irq_en 0, rd_valid 0, rd_data 0, irq 0.

## Timing
- rd_valid and rd_data are registered; they reflect state sampled in the rd_req cycle. rd_data is held at its last value when rd_valid=0.
- snap_valid at cycle N: the record is visible to a read issued at N+1, and irq rises at N+1 if irq_en=1.
- POP write at cycle N: the next record is visible to a read issued at N+1, and irq falls at N+1 if the FIFO became empty.
- irq is registered, so there is no combinational path from inputs.
- Reset asserted mid-operation clears state on the next edge; a snap_valid in the reset cycle is discarded.
- No back-pressure exists on either port; every strobe completes in one cycle.

## Structure
- Package perf_pkg holds:
  - register offset localparams (STATUS..CTRL)
  - STATUS bit positions
  - packed struct perf_snap_t (six 32-bit fields, 192 bits)
- Sub-module perf_snap_fifo: synchronous FIFO of perf_snap_t, DEPTH entries, with push, pop, flush, full, empty and level outputs. Pointers carry one extra wrap bit.
- perf_readout contains the register decode, overflow logic, irq register, and zero-extension of COUNTER_WIDTH fields.

## Test plan
- Reset, then read 0x00 -> 0x00000001 (empty); irq=0; read 0x04 -> 0.
- Set irq_en; push total=100, active=60, idle=40, dma=4096, blocks=16, stalls=7 -> irq=1 one cycle later; reads return those values; STATUS level=1; POP -> irq=0, STATUS=0x00000001.
- Push 5 records (DEPTH=4) with total=1..5 -> STATUS full, ovf=1, count=1; pop-reads return 1,2,3,4 in order; write 0x04 to STATUS -> bit2 and count cleared.
- FIFO full; push total=9 together with POP in the same cycle -> level stays 4, no overflow; the last record read is 9.
- Two records queued; flush together with snap_valid in the same cycle -> STATUS=0x00000001 and overflow count unchanged.
- COUNTER_WIDTH=16, snap_total=0xFFFF -> TOTAL reads 0x0000FFFF; back-to-back rd_req every cycle returns data for each request exactly one cycle later.

Source files
------------

// File: rtl/perf_readout_pkg.sv
// Shared definitions for the performance-counter readout path: CSR map,
// STATUS/CTRL bit positions and the snapshot record layout.
package perf_pkg;

  localparam logic [7:0] ADDR_STATUS    = 8'h00;
  localparam logic [7:0] ADDR_TOTAL     = 8'h04;
  localparam logic [7:0] ADDR_ACTIVE    = 8'h08;
  localparam logic [7:0] ADDR_IDLE      = 8'h0C;
  localparam logic [7:0] ADDR_DMA_BYTES = 8'h10;
  localparam logic [7:0] ADDR_BLOCKS    = 8'h14;
  localparam logic [7:0] ADDR_STALLS    = 8'h18;
  localparam logic [7:0] ADDR_POP       = 8'h1C;
  localparam logic [7:0] ADDR_CTRL      = 8'h20;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_LEVEL_LSB = 8;
  localparam int unsigned ST_CNT_LSB   = 16;

  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_FLUSH  = 1;

  typedef struct packed {
    logic [31:0] total;
    logic [31:0] active;
    logic [31:0] idle;
    logic [31:0] dma_bytes;
    logic [31:0] blocks;
    logic [31:0] stalls;
  } perf_snap_t;

endpackage

// File: rtl/perf_readout_if.sv
// Snapshot input, CSR read/write port and interrupt of perf_readout.
interface perf_readout_if #(
  parameter int unsigned COUNTER_WIDTH = 32
);
  logic                     snap_valid;
  logic [COUNTER_WIDTH-1:0] snap_total;
  logic [COUNTER_WIDTH-1:0] snap_active;
  logic [COUNTER_WIDTH-1:0] snap_idle;
  logic [31:0]              snap_dma_bytes;
  logic [31:0]              snap_blocks;
  logic [31:0]              snap_stalls;
  logic                     rd_req;
  logic [7:0]               rd_addr;
  logic                     rd_valid;
  logic [31:0]              rd_data;
  logic                     wr_req;
  logic [7:0]               wr_addr;
  logic [31:0]              wr_data;
  logic                     irq;

  modport master (
    output snap_valid, snap_total, snap_active, snap_idle,
           snap_dma_bytes, snap_blocks, snap_stalls,
           rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_valid, rd_data, irq
  );

  modport slave (
    input  snap_valid, snap_total, snap_active, snap_idle,
           snap_dma_bytes, snap_blocks, snap_stalls,
           rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_valid, rd_data, irq
  );
endinterface

// File: rtl/perf_readout_snap_fifo.sv
// Synchronous FIFO of snapshot records. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module perf_snap_fifo
  import perf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  perf_snap_t               i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output perf_snap_t               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int unsigned AW = $clog2(DEPTH);

  perf_snap_t    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (o_level == (AW+1)'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Pointer update; flush overrides any concurrent push/pop.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Record storage; contents are only observed through non-empty reads.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush && w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/perf_readout.sv
// Captures performance snapshots into a FIFO and exposes them to software
// through a one-cycle CSR port with pop-on-write and a pending interrupt.
module perf_readout
  import perf_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned DEPTH         = 4
) (
  input logic           clk,
  input logic           rst,
  perf_readout_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  perf_snap_t  w_snap;
  perf_snap_t  w_head_raw;
  perf_snap_t  w_head;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_level;
  logic [7:0]  w_rd_addr;
  logic [7:0]  w_wr_addr;
  logic        w_pop_cmd;
  logic        w_ctrl_wr;
  logic        w_flush;
  logic        w_ovf_clr;
  logic        w_pop_ok;
  logic        w_push_ok;
  logic        w_ovf_evt;
  logic        w_irq_en_nxt;
  logic        w_nonempty_nxt;
  logic [31:0] w_status;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  logic        r_irq_en;
  logic        r_ovf;
  logic [15:0] r_ovf_cnt;
  logic        r_irq;
  logic        r_rd_valid;
  logic [31:0] r_rd_data;

  assign w_snap = '{
    total:     32'(bus.snap_total),
    active:    32'(bus.snap_active),
    idle:      32'(bus.snap_idle),
    dma_bytes: bus.snap_dma_bytes,
    blocks:    bus.snap_blocks,
    stalls:    bus.snap_stalls
  };

  assign w_rd_addr = {bus.rd_addr[7:2], 2'b00};
  assign w_wr_addr = {bus.wr_addr[7:2], 2'b00};
  assign w_pop_cmd = bus.wr_req && (w_wr_addr == ADDR_POP);
  assign w_ctrl_wr = bus.wr_req && (w_wr_addr == ADDR_CTRL);
  assign w_flush   = w_ctrl_wr && bus.wr_data[CTRL_FLUSH];
  assign w_ovf_clr = bus.wr_req && (w_wr_addr == ADDR_STATUS) && bus.wr_data[ST_OVF];
  assign w_unused  = ^{bus.rd_addr[1:0], bus.wr_addr[1:0], bus.wr_data[31:3]};

  perf_snap_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.snap_valid),
    .i_data  (w_snap),
    .i_pop   (w_pop_cmd),
    .i_flush (w_flush),
    .o_head  (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_head    = w_empty ? '0 : w_head_raw;
  assign w_pop_ok  = w_pop_cmd && !w_empty;
  assign w_push_ok = bus.snap_valid && (!w_full || w_pop_ok);
  // When full the FIFO is never empty, so only a pop command can make room.
  assign w_ovf_evt = bus.snap_valid && w_full && !w_pop_cmd && !w_flush;

  // irq is registered from next-state so it tracks the FIFO in the same cycle
  // the new level becomes visible to reads.
  assign w_irq_en_nxt   = w_ctrl_wr ? bus.wr_data[CTRL_IRQ_EN] : r_irq_en;
  assign w_nonempty_nxt = !w_flush && (w_push_ok || (w_level > (AW+1)'(w_pop_ok)));

  assign w_status = {r_ovf_cnt, 8'(w_level), 5'b0, r_ovf, w_full, w_empty};

  // CSR read multiplexer over pre-write state.
  always_comb begin
    w_rd_mux = '0;
    case (w_rd_addr)
      ADDR_STATUS:    w_rd_mux = w_status;
      ADDR_TOTAL:     w_rd_mux = w_head.total;
      ADDR_ACTIVE:    w_rd_mux = w_head.active;
      ADDR_IDLE:      w_rd_mux = w_head.idle;
      ADDR_DMA_BYTES: w_rd_mux = w_head.dma_bytes;
      ADDR_BLOCKS:    w_rd_mux = w_head.blocks;
      ADDR_STALLS:    w_rd_mux = w_head.stalls;
      ADDR_CTRL:      w_rd_mux = {31'b0, r_irq_en};
      default:        w_rd_mux = '0;
    endcase
  end

  // Control/overflow state and the interrupt register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en  <= 1'b0;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_nxt;
      // A concurrent W1C clears first, then the overflow event is applied.
      if (w_ovf_evt) begin
        r_ovf     <= 1'b1;
        r_ovf_cnt <= w_ovf_clr ? 16'd1
                   : (r_ovf_cnt == 16'hFFFF) ? r_ovf_cnt : r_ovf_cnt + 16'd1;
      end else if (w_ovf_clr) begin
        r_ovf     <= 1'b0;
        r_ovf_cnt <= '0;
      end
      r_irq <= w_irq_en_nxt && w_nonempty_nxt;
    end
  end

  // Registered read response; data holds its last value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) r_rd_data <= w_rd_mux;
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.irq      = r_irq;
endmodule

// File: tb/tb_perf_readout.sv
// Directed bench for perf_readout: a 32-bit counter instance for the main
// CSR/FIFO behaviour and a 16-bit instance for zero-extension and
// back-to-back reads.
module tb_perf_readout;
  import perf_pkg::*;

  logic clk;
  logic rst;
  int unsigned n_chk;
  int unsigned n_err;
  logic [31:0] d;

  perf_readout_if #(.COUNTER_WIDTH(32)) bus ();
  perf_readout_if #(.COUNTER_WIDTH(16)) bus16 ();

  perf_readout #(.COUNTER_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  perf_readout #(.COUNTER_WIDTH(16), .DEPTH(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_snap(input logic [31:0] t, input logic [31:0] a, input logic [31:0] i,
                          input logic [31:0] dm, input logic [31:0] b, input logic [31:0] s);
    bus.snap_valid     = 1'b1;
    bus.snap_total     = t;
    bus.snap_active    = a;
    bus.snap_idle      = i;
    bus.snap_dma_bytes = dm;
    bus.snap_blocks    = b;
    bus.snap_stalls    = s;
  endtask

  task automatic push(input logic [31:0] t);
    set_snap(t, 0, 0, 0, 0, 0);
    tick();
    bus.snap_valid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = v;
    tick();
    bus.wr_req  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_req  = 1'b0;
    chk("rd_valid", 32'(bus.rd_valid), 32'd1);
    v = bus.rd_data;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.snap_valid = 0; bus.snap_total = 0; bus.snap_active = 0; bus.snap_idle = 0;
    bus.snap_dma_bytes = 0; bus.snap_blocks = 0; bus.snap_stalls = 0;
    bus.rd_req = 0; bus.rd_addr = 0; bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus16.snap_valid = 0; bus16.snap_total = 0; bus16.snap_active = 0; bus16.snap_idle = 0;
    bus16.snap_dma_bytes = 0; bus16.snap_blocks = 0; bus16.snap_stalls = 0;
    bus16.rd_req = 0; bus16.rd_addr = 0; bus16.wr_req = 0; bus16.wr_addr = 0; bus16.wr_data = 0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_data", bus.rd_data, 0);
    rd_chk("rst_status", ADDR_STATUS, 32'h0000_0001);
    rd_chk("rst_total", ADDR_TOTAL, 0);
    rd_chk("rst_ctrl", ADDR_CTRL, 0);

    // Single record, irq, field readout, pop
    wr(ADDR_CTRL, 32'h1);
    chk("irq_empty", 32'(bus.irq), 0);
    set_snap(100, 60, 40, 4096, 16, 7);
    tick();
    bus.snap_valid = 1'b0;
    chk("irq_rise", 32'(bus.irq), 1);
    rd_chk("f_total", ADDR_TOTAL, 100);
    rd_chk("f_active", ADDR_ACTIVE, 60);
    rd_chk("f_idle", ADDR_IDLE, 40);
    rd_chk("f_dma", ADDR_DMA_BYTES, 4096);
    rd_chk("f_blocks", ADDR_BLOCKS, 16);
    rd_chk("f_stalls", ADDR_STALLS, 7);
    rd_chk("st_lvl1", ADDR_STATUS, 32'h0000_0100);
    rd_chk("pop_reads0", ADDR_POP, 0);
    wr(ADDR_POP, 0);
    chk("irq_fall", 32'(bus.irq), 0);
    rd_chk("st_after_pop", ADDR_STATUS, 32'h0000_0001);
    wr(ADDR_POP, 0);
    rd_chk("pop_empty", ADDR_STATUS, 32'h0000_0001);

    // Overflow: 5 pushes into depth 4, oldest preserved
    for (int i = 1; i <= 5; i++) push(32'(i));
    rd_chk("st_ovf", ADDR_STATUS, 32'h0001_0406);
    for (int i = 1; i <= 4; i++) begin
      rd_chk("ovf_order", ADDR_TOTAL, 32'(i));
      wr(ADDR_POP, 0);
    end
    rd_chk("st_ovf_empty", ADDR_STATUS, 32'h0001_0005);
    wr(ADDR_STATUS, 32'h4);
    rd_chk("st_w1c", ADDR_STATUS, 32'h0000_0001);

    // Push and pop together while full
    for (int i = 11; i <= 14; i++) push(32'(i));
    chk("irq_full", 32'(bus.irq), 1);
    set_snap(9, 0, 0, 0, 0, 0);
    bus.wr_req = 1'b1; bus.wr_addr = ADDR_POP; bus.wr_data = 0;
    tick();
    bus.snap_valid = 1'b0; bus.wr_req = 1'b0;
    rd_chk("st_pushpop", ADDR_STATUS, 32'h0000_0402);
    for (int i = 0; i < 4; i++) begin
      rd_chk("pp_order", ADDR_TOTAL, (i == 3) ? 32'd9 : 32'(12 + i));
      wr(ADDR_POP, 0);
    end
    rd_chk("st_pp_empty", ADDR_STATUS, 32'h0000_0001);

    // Overflow event and W1C in the same cycle
    for (int i = 21; i <= 25; i++) push(32'(i));
    set_snap(26, 0, 0, 0, 0, 0);
    bus.wr_req = 1'b1; bus.wr_addr = ADDR_STATUS; bus.wr_data = 32'h4;
    tick();
    bus.snap_valid = 1'b0; bus.wr_req = 1'b0;
    rd_chk("st_evt_wins", ADDR_STATUS, 32'h0001_0406);
    rd_chk("evt_head", ADDR_TOTAL, 21);

    // Flush, then flush with a concurrent push
    wr(ADDR_CTRL, 32'h3);
    rd_chk("st_flush", ADDR_STATUS, 32'h0001_0005);
    rd_chk("ctrl_rd", ADDR_CTRL, 32'h1);
    push(31);
    push(32);
    rd_chk("st_two", ADDR_STATUS, 32'h0001_0204);
    set_snap(33, 0, 0, 0, 0, 0);
    bus.wr_req = 1'b1; bus.wr_addr = ADDR_CTRL; bus.wr_data = 32'h3;
    tick();
    bus.snap_valid = 1'b0; bus.wr_req = 1'b0;
    chk("irq_flush", 32'(bus.irq), 0);
    rd_chk("st_flush_push", ADDR_STATUS, 32'h0001_0005);
    rd_chk("unmapped", 8'h24, 0);

    // Read and write in the same cycle return the pre-write value
    bus.rd_req = 1'b1; bus.rd_addr = ADDR_STATUS;
    bus.wr_req = 1'b1; bus.wr_addr = ADDR_STATUS; bus.wr_data = 32'h4;
    tick();
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    chk("rw_valid", 32'(bus.rd_valid), 1);
    chk("rw_prewrite", bus.rd_data, 32'h0001_0005);
    rd_chk("rw_after", ADDR_STATUS, 32'h0000_0001);

    // Reset mid-operation discards a concurrent snapshot
    push(41);
    chk("irq_pre_rst", 32'(bus.irq), 1);
    set_snap(42, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.snap_valid = 1'b0;
    chk("irq_rst", 32'(bus.irq), 0);
    rd_chk("st_rst", ADDR_STATUS, 32'h0000_0001);
    rd_chk("ctrl_rst", ADDR_CTRL, 0);

    // 16-bit counters: zero-extension and back-to-back reads
    bus16.snap_valid  = 1'b1;
    bus16.snap_total  = 16'hFFFF;
    bus16.snap_active = 16'h1234;
    tick();
    bus16.snap_valid = 1'b0;
    bus16.rd_req = 1'b1; bus16.rd_addr = ADDR_TOTAL;
    tick();
    chk("b2b_v0", 32'(bus16.rd_valid), 1);
    chk("w16_total", bus16.rd_data, 32'h0000_FFFF);
    bus16.rd_addr = ADDR_ACTIVE;
    tick();
    chk("b2b_v1", 32'(bus16.rd_valid), 1);
    chk("w16_active", bus16.rd_data, 32'h0000_1234);
    bus16.rd_addr = ADDR_STATUS;
    tick();
    chk("b2b_v2", 32'(bus16.rd_valid), 1);
    chk("w16_status", bus16.rd_data, 32'h0000_0100);
    bus16.rd_req = 1'b0;
    tick();
    chk("b2b_idle", 32'(bus16.rd_valid), 0);
    chk("b2b_hold", bus16.rd_data, 32'h0000_0100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
